ps2_key_decoder: RTL and testbench

Turns the raw PS/2 byte stream from the keyboard controller into buffered key events for the processor and LCD path. Takes each received byte (`ps2_key_data` qualified by the one-cycle `ps2_key_pressed` strobe) and parses make, break (F0) and extended (E0) sequences. Mapped make codes become 8-bit key codes in a small FIFO that the processor pops. The block also keeps a held-key bitmask and a registered last-key byte for the LCD. It replaces the ad-hoc combinational scancode mux in the top level.

---
 rtl/ps2_keys_pkg.sv | 72 +++++++
 rtl/key_fifo.sv | 74 +++++++
 rtl/ps2_key_decoder.sv | 110 +++++++++++
 tb/tb_ps2_key_decoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 scancode and key-code constants, the parser state type and
// the scancode-to-key mapping used by the key decoder.
package ps2_keys_pkg;

  localparam int NKEYS = 12;

  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E0 = 8'hE0;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] KC_A     = 8'h61;
  localparam logic [7:0] KC_Q     = 8'h71;
  localparam logic [7:0] KC_D     = 8'h64;
  localparam logic [7:0] KC_F     = 8'h66;
  localparam logic [7:0] KC_W     = 8'h77;
  localparam logic [7:0] KC_S     = 8'h73;
  localparam logic [7:0] KC_SPACE = 8'h20;
  localparam logic [7:0] KC_ENTER = 8'h0D;
  localparam logic [7:0] KC_UP    = 8'h80;
  localparam logic [7:0] KC_DOWN  = 8'h81;
  localparam logic [7:0] KC_LEFT  = 8'h82;
  localparam logic [7:0] KC_RIGHT = 8'h83;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parse_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
    logic [7:0] code;
  } key_map_t;

  // Normal codes only match without E0; arrows only match with it.
  function automatic key_map_t map_key(input logic [7:0] sc, input logic ext);
    key_map_t r;
    r = '0;
    if (!ext) begin
      case (sc)
        SC_A:     r = '{hit: 1'b1, idx: 4'd0, code: KC_A};
        SC_Q:     r = '{hit: 1'b1, idx: 4'd1, code: KC_Q};
        SC_D:     r = '{hit: 1'b1, idx: 4'd2, code: KC_D};
        SC_F:     r = '{hit: 1'b1, idx: 4'd3, code: KC_F};
        SC_W:     r = '{hit: 1'b1, idx: 4'd4, code: KC_W};
        SC_S:     r = '{hit: 1'b1, idx: 4'd5, code: KC_S};
        SC_SPACE: r = '{hit: 1'b1, idx: 4'd6, code: KC_SPACE};
        SC_ENTER: r = '{hit: 1'b1, idx: 4'd7, code: KC_ENTER};
        default:  r = '0;
      endcase
    end else begin
      case (sc)
        SC_UP:    r = '{hit: 1'b1, idx: 4'd8,  code: KC_UP};
        SC_DOWN:  r = '{hit: 1'b1, idx: 4'd9,  code: KC_DOWN};
        SC_LEFT:  r = '{hit: 1'b1, idx: 4'd10, code: KC_LEFT};
        SC_RIGHT: r = '{hit: 1'b1, idx: 4'd11, code: KC_RIGHT};
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word fall-through FIFO for decoded key codes with a sticky
// overflow flag for dropped pushes.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  input  logic                     clr_overflow,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = (overflow_q && !clr_overflow) || (push && !do_push);
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Parses PS/2 make/break/extended byte sequences into buffered key codes,
// a held-key bitmask and a last-key register for the LCD.
module ps2_key_decoder
  import ps2_keys_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             ps2_key_data,
  input  logic                   ps2_key_pressed,
  input  logic                   rd_en,
  input  logic                   clr_overflow,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [NKEYS-1:0]       held,
  output logic [7:0]             last_key
);
  parse_state_e     state_q, state_d;
  logic             done, is_brk, is_ext;
  logic             make_ev, brk_ev, push;
  key_map_t         km;
  logic [NKEYS-1:0] held_q, held_d;
  logic [7:0]       last_key_q, last_key_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ps2_key_pressed) begin
      case (state_q)
        IDLE: begin
          if (ps2_key_data == SC_F0)      state_d = BRK;
          else if (ps2_key_data == SC_E0) state_d = EXT;
        end
        EXT:     state_d = (ps2_key_data == SC_F0) ? EXT_BRK : IDLE;
        BRK:     state_d = IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // done marks the byte that completes a sequence; prefixes never do.
  always_comb begin
    done   = 1'b0;
    is_brk = 1'b0;
    is_ext = 1'b0;
    if (ps2_key_pressed) begin
      case (state_q)
        IDLE:    done = (ps2_key_data != SC_F0) && (ps2_key_data != SC_E0);
        EXT:     begin done = (ps2_key_data != SC_F0); is_ext = 1'b1; end
        BRK:     begin done = 1'b1; is_brk = 1'b1; end
        EXT_BRK: begin done = 1'b1; is_brk = 1'b1; is_ext = 1'b1; end
        default: done = 1'b0;
      endcase
    end
    km      = map_key(ps2_key_data, is_ext);
    make_ev = done && !is_brk && km.hit;
    brk_ev  = done &&  is_brk && km.hit;
  end

  always_comb begin
    held_d     = held_q;
    last_key_d = last_key_q;
    push       = 1'b0;
    if (make_ev) begin
      held_d[km.idx] = 1'b1;
      push           = REPEAT_EN || !held_q[km.idx];
    end else if (brk_ev) begin
      held_d[km.idx] = 1'b0;
    end
    if (push) last_key_d = km.code;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_q     <= '0;
      last_key_q <= '0;
    end else begin
      held_q     <= held_d;
      last_key_q <= last_key_d;
    end
  end

  assign held     = held_q;
  assign last_key = last_key_q;

  key_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .wr_data      (km.code),
    .pop          (rd_en),
    .clr_overflow (clr_overflow),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: two instances (repeat suppressed / repeat
// pushed) driven in lockstep and compared with a queue-based reference.
module tb_ps2_key_decoder;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_key_data = 8'h00;
  logic       ps2_key_pressed = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_overflow = 1'b0;

  logic [7:0]  rd_data0, rd_data1, last0, last1;
  logic        empty0, empty1, full0, full1, ovf0, ovf1;
  logic [3:0]  count0, count1;
  logic [11:0] held0, held1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ps2_key_decoder #(.DEPTH(DEPTH), .REPEAT_EN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed), .rd_en(rd_en), .clr_overflow(clr_overflow),
    .rd_data(rd_data0), .empty(empty0), .full(full0), .count(count0),
    .overflow(ovf0), .held(held0), .last_key(last0));

  ps2_key_decoder #(.DEPTH(DEPTH), .REPEAT_EN(1'b1)) dut1 (
    .clock(clock), .reset(reset), .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed), .rd_en(rd_en), .clr_overflow(clr_overflow),
    .rd_data(rd_data1), .empty(empty1), .full(full1), .count(count1),
    .overflow(ovf1), .held(held1), .last_key(last1));

  // Reference model: prefix flags, key table, one queue per instance.
  byte unsigned sc_tab[12]   = '{8'h1C, 8'h15, 8'h23, 8'h2B, 8'h1D, 8'h1B, 8'h29, 8'h5A,
                                 8'h75, 8'h72, 8'h6B, 8'h74};
  byte unsigned code_tab[12] = '{8'h61, 8'h71, 8'h64, 8'h66, 8'h77, 8'h73, 8'h20, 8'h0D,
                                 8'h80, 8'h81, 8'h82, 8'h83};
  bit           m_e0, m_f0;
  bit [11:0]    m_held;
  byte unsigned mq[2][$];
  bit           m_ovf[2];
  byte unsigned m_last[2];

  function automatic int lookup(input byte unsigned sc, input bit ext);
    for (int i = 0; i < 12; i++)
      if (sc_tab[i] == sc && ((i >= 8) == ext)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_e0 = 0; m_f0 = 0; m_held = '0;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete(); m_ovf[k] = 0; m_last[k] = 8'h00;
    end
  endtask

  task automatic model_step(input byte unsigned d, input bit s, input bit r, input bit c);
    bit fin = 0, brk = 0, ext = 0, mk, bk, preq, pop, drop;
    int idx;
    if (s) begin
      if (d == 8'hF0 && !m_f0) m_f0 = 1;
      else if (d == 8'hE0 && !m_e0 && !m_f0) m_e0 = 1;
      else begin fin = 1; brk = m_f0; ext = m_e0; m_f0 = 0; m_e0 = 0; end
    end
    idx = fin ? lookup(d, ext) : -1;
    mk = (idx >= 0) && !brk;
    bk = (idx >= 0) && brk;
    for (int k = 0; k < 2; k++) begin
      preq = mk && (k == 1 || !m_held[idx]);
      pop  = r && mq[k].size() > 0;
      drop = preq && mq[k].size() == DEPTH && !pop;
      if (pop) void'(mq[k].pop_front());
      if (preq && !drop) mq[k].push_back(code_tab[idx]);
      m_ovf[k] = (m_ovf[k] && !c) || drop;
      if (preq) m_last[k] = code_tab[idx];
    end
    if (mk) m_held[idx] = 1'b1;
    if (bk) m_held[idx] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("empty0", 32'(empty0), 32'(mq[0].size() == 0));
    chk("empty1", 32'(empty1), 32'(mq[1].size() == 0));
    chk("full0", 32'(full0), 32'(mq[0].size() == DEPTH));
    chk("full1", 32'(full1), 32'(mq[1].size() == DEPTH));
    chk("count0", 32'(count0), 32'(mq[0].size()));
    chk("count1", 32'(count1), 32'(mq[1].size()));
    chk("ovf0", 32'(ovf0), 32'(m_ovf[0]));
    chk("ovf1", 32'(ovf1), 32'(m_ovf[1]));
    chk("held0", 32'(held0), 32'(m_held));
    chk("held1", 32'(held1), 32'(m_held));
    chk("last0", 32'(last0), 32'(m_last[0]));
    chk("last1", 32'(last1), 32'(m_last[1]));
    if (mq[0].size() > 0) chk("rd_data0", 32'(rd_data0), 32'(mq[0][0]));
    if (mq[1].size() > 0) chk("rd_data1", 32'(rd_data1), 32'(mq[1][0]));
  endtask

  // Drive one cycle's inputs, update the model at the edge, check at negedge.
  task automatic cyc(input logic [7:0] d, input bit s, input bit r, input bit c);
    ps2_key_data = d; ps2_key_pressed = s; rd_en = r; clr_overflow = c;
    @(posedge clock);
    model_step(d, s, r, c);
    #1;
    ps2_key_pressed = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;
    @(negedge clock);
    check_all();
  endtask

  task automatic key(input logic [7:0] d);
    cyc(d, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    byte unsigned b;
    int sel;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_all();
    chk("rst_rd0", 32'(rd_data0), 32'h00);
    chk("rst_rd1", 32'(rd_data1), 32'h00);

    // Single make then its break.
    key(8'h1C);
    chk("a_rd", 32'(rd_data0), 32'h61);
    chk("a_held", 32'(held0[0]), 32'h1);
    chk("a_last", 32'(last0), 32'h61);
    key(8'hF0); key(8'h1C);
    chk("a_brk_held", 32'(held0[0]), 32'h0);
    chk("a_brk_cnt", 32'(count0), 32'h1);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);

    // Extended make/break.
    key(8'hE0); key(8'h75);
    chk("up_held", 32'(held0[8]), 32'h1);
    chk("up_rd", 32'(rd_data0), 32'h80);
    key(8'hE0); key(8'hF0); key(8'h75);
    chk("up_brk_held", 32'(held0[8]), 32'h0);
    chk("up_cnt", 32'(count0), 32'h1);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);

    // Typematic repeat.
    key(8'h1D); key(8'h1D); key(8'h1D);
    chk("rep0_cnt", 32'(count0), 32'h1);
    chk("rep1_cnt", 32'(count1), 32'h3);
    key(8'hF0); key(8'h1D);
    repeat (4) cyc(8'h00, 1'b0, 1'b1, 1'b0);

    // Overflow with nine distinct makes.
    for (int i = 0; i < 8; i++) key(sc_tab[i]);
    key(8'hE0); key(8'h72);
    chk("ovf_full", 32'(full0), 32'h1);
    chk("ovf_cnt", 32'(count0), 32'h8);
    chk("ovf_flag", 32'(ovf0), 32'h1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf0), 32'h0);

    // Push and pop together while full.
    key(8'hE0);
    cyc(8'h74, 1'b1, 1'b1, 1'b0);
    chk("fp_cnt", 32'(count0), 32'h8);
    chk("fp_head", 32'(rd_data0), 32'h71);
    repeat (10) cyc(8'h00, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty0), 32'h1);
    // Push plus pop into an empty FIFO acts as a push.
    key(8'hF0); key(8'h1C);
    cyc(8'h1C, 1'b1, 1'b1, 1'b0);
    chk("ep_cnt", 32'(count0), 32'h1);
    cyc(8'h00, 1'b0, 1'b1, 1'b0);

    // Reset mid-sequence discards the E0 prefix.
    key(8'hE0);
    reset = 1'b1;
    #2;
    model_reset();
    chk("mid_rst_held", 32'(held0), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    check_all();
    key(8'h75);
    chk("post_rst_empty", 32'(empty0), 32'h1);
    chk("post_rst_held", 32'(held0), 32'h0);

    // Randomised byte stream.
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 15));
      if (sel < 10)       b = sc_tab[$urandom_range(0, 11)];
      else if (sel < 12)  b = 8'hE0;
      else if (sel < 14)  b = 8'hF0;
      else                b = 8'($urandom);
      cyc(b, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
